// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage pipelined ARM CPU.
//
// Owns the program counter and fetches instruction words over a req/ack
// handshake. Each accepted word goes into the IF/ID pipeline register, which
// feeds the decode stage and the control unit. The hazard unit can stall the
// stage. Branches resolved further down the pipe redirect and flush it.
//
// Parameters
//   PC_W      program-counter / fetch-address width
//   RESET_PC  PC value loaded by reset
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous, active-low reset
//   imem_req     fetch request; imem_addr is held stable while it waits for ack
//   imem_addr    fetch address
//   imem_ack     imem_rdata is valid this cycle (may arrive with the request)
//   imem_rdata   fetched instruction word
//   stall        freeze IF/ID (load-use hazard)
//   redirect     taken branch: flush IF/ID and refetch from redirect_pc
//   redirect_pc  new PC; the low two bits are ignored
//   ifid_valid   IF/ID holds a real instruction
//   ifid_instr   IF/ID instruction word
//   ifid_pc      address of ifid_instr
//   ifid_opcode  ifid_instr[31:21], the control-unit opcode field
//   perf_fetched count of valid IF/ID loads
//   perf_bubbles count of unstalled edges that loaded an empty IF/ID
//
// Build option
//   IF_PERF_EN   when defined, both performance counters are implemented.
//                Otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module if_stage #(
   parameter int             PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic            ifid_valid,
   output logic [31:0]     ifid_instr,
   output logic [PC_W-1:0] ifid_pc,
   output logic [10:0]     ifid_opcode,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_bubbles
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } stateT;

   stateT           state;
   stateT           stateNext;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pcNext;
   logic [PC_W-1:0] reqAddr;
   logic [PC_W-1:0] reqAddrNext;
   logic [31:0]     holdBuf;
   logic [31:0]     holdBufNext;
   logic            ifidValidNext;
   logic [31:0]     ifidInstrNext;
   logic [PC_W-1:0] ifidPcNext;
   logic [PC_W-1:0] redirectAligned;
   logic [PC_W-1:0] seqAddr;

   // Branch targets are always word aligned, so the low two bits of
   // redirect_pc are cleared rather than trusted. The next sequential fetch
   // address wraps silently at the top of the address space.
   assign redirectAligned = redirect_pc & ~PC_W'(3);
   assign seqAddr         = reqAddr + PC_W'(4);

   // A request is outstanding in FETCH and DRAIN. HOLD already has its word
   // buffered, so it does not request. Reset masks the request so that the
   // memory never sees one while rst is low.
   assign imem_req    = rst && (state != HOLD);
   assign imem_addr   = reqAddr;
   assign ifid_opcode = ifid_instr[31:21];

   // Next-state and datapath decisions. The order of the checks gives redirect
   // priority over stall. A redirect flushes IF/ID even when stall is high.
   // DRAIN waits for the stale request that was in flight when the redirect
   // arrived. Its data is thrown away, and then fetching restarts from the
   // newest pc. A redirect during DRAIN only updates pc, because the old
   // address has to stay on the bus until that request is acknowledged.
   always_comb begin
      stateNext     = state;
      pcNext        = pc;
      reqAddrNext   = reqAddr;
      holdBufNext   = holdBuf;
      ifidValidNext = ifid_valid;
      ifidInstrNext = ifid_instr;
      ifidPcNext    = ifid_pc;
      case (state)
         FETCH: begin
            if (redirect) begin
               pcNext        = redirectAligned;
               ifidValidNext = 1'b0;
               if (imem_ack) begin
                  reqAddrNext = redirectAligned;
               end else begin
                  stateNext = DRAIN;
               end
            end else if (imem_ack) begin
               if (stall) begin
                  holdBufNext = imem_rdata;
                  stateNext   = HOLD;
               end else begin
                  ifidValidNext = 1'b1;
                  ifidInstrNext = imem_rdata;
                  ifidPcNext    = reqAddr;
                  reqAddrNext   = seqAddr;
                  pcNext        = seqAddr;
               end
            end else if (!stall) begin
               ifidValidNext = 1'b0;
            end
         end
         HOLD: begin
            if (redirect) begin
               reqAddrNext   = redirectAligned;
               pcNext        = redirectAligned;
               ifidValidNext = 1'b0;
               stateNext     = FETCH;
            end else if (!stall) begin
               ifidValidNext = 1'b1;
               ifidInstrNext = holdBuf;
               ifidPcNext    = reqAddr;
               reqAddrNext   = seqAddr;
               pcNext        = seqAddr;
               stateNext     = FETCH;
            end
         end
         DRAIN: begin
            ifidValidNext = 1'b0;
            if (redirect) begin
               pcNext = redirectAligned;
            end
            if (imem_ack) begin
               reqAddrNext = redirect ? redirectAligned : pc;
               stateNext   = FETCH;
            end
         end
         default: begin
            stateNext = FETCH;
         end
      endcase
   end

   // State register together with the pc, the request address, the one-word
   // hold buffer and the IF/ID pipeline register. Reset is synchronous and
   // also drops any outstanding request, because the memory is reset at the
   // same time.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         reqAddr    <= RESET_PC;
         holdBuf    <= '0;
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc    <= '0;
      end else begin
         state      <= stateNext;
         pc         <= pcNext;
         reqAddr    <= reqAddrNext;
         holdBuf    <= holdBufNext;
         ifid_valid <= ifidValidNext;
         ifid_instr <= ifidInstrNext;
         ifid_pc    <= ifidPcNext;
      end
   end

`ifdef IF_PERF_EN
   logic [31:0] fetchedCnt;
   logic [31:0] bubbleCnt;

   // IF/ID is rewritten on every edge where stall is low, and valid loads
   // only ever happen on such edges. So an unstalled edge counts as a fetch
   // if the new IF/ID content is valid, and as a bubble otherwise.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetchedCnt <= '0;
         bubbleCnt  <= '0;
      end else if (!stall) begin
         if (ifidValidNext) begin
            fetchedCnt <= fetchedCnt + 32'd1;
         end else begin
            bubbleCnt <= bubbleCnt + 32'd1;
         end
      end
   end

   assign perf_fetched = fetchedCnt;
   assign perf_bubbles = bubbleCnt;
`else
   assign perf_fetched = '0;
   assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
//
// A short directed sequence covers the scenarios of interest. It is followed
// by a long randomized run. After every clock edge the DUT outputs are
// compared against a transaction-level reference model of the fetch stage.
// The model tracks a queue of buffered words, a flag for a stale outstanding
// request, and the IF/ID contents.
// ---------------------------------------------------------------------------
module tb_if_stage;

   localparam int PC_W = 64;

   logic            clk;
   logic            rst;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic            stall;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;
   logic            ifid_valid;
   logic [31:0]     ifid_instr;
   logic [PC_W-1:0] ifid_pc;
   logic [10:0]     ifid_opcode;
   logic [31:0]     perf_fetched;
   logic [31:0]     perf_bubbles;

   int checks = 0;
   int errors = 0;

   logic            mRst;
   logic [PC_W-1:0] mReqA;
   logic [PC_W-1:0] mPc;
   bit              mStale;
   logic [31:0]     mHoldQ[$];
   logic            mValid;
   logic [31:0]     mInstr;
   logic [PC_W-1:0] mIfPc;
   logic [31:0]     mFetched;
   logic [31:0]     mBubbles;

   if_stage #(.PC_W(PC_W), .RESET_PC('0)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ifid_valid  (ifid_valid),
      .ifid_instr  (ifid_instr),
      .ifid_pc     (ifid_pc),
      .ifid_opcode (ifid_opcode),
      .perf_fetched(perf_fetched),
      .perf_bubbles(perf_bubbles)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // The model requests memory whenever it is out of reset and has no word
   // parked in its buffer.
   function automatic logic modelReq();
      return mRst && (mHoldQ.size() == 0);
   endfunction

   // One clock edge of the reference model, applied with the inputs that
   // are currently being driven.
   task automatic modelStep();
      logic [PC_W-1:0] target;
      logic            loadOne;
      logic [31:0]     word;
      target  = redirect_pc & ~64'h3;
      loadOne = 1'b0;
      if (!rst) begin
         mReqA    = '0;
         mPc      = '0;
         mStale   = 1'b0;
         mHoldQ.delete();
         mValid   = 1'b0;
         mInstr   = '0;
         mIfPc    = '0;
         mFetched = '0;
         mBubbles = '0;
      end else begin
         if (mHoldQ.size() > 0) begin
            if (redirect) begin
               mHoldQ.delete();
               mReqA  = target;
               mPc    = target;
               mValid = 1'b0;
            end else if (!stall) begin
               word    = mHoldQ.pop_front();
               mValid  = 1'b1;
               mInstr  = word;
               mIfPc   = mReqA;
               mReqA   = mReqA + 64'd4;
               mPc     = mReqA;
               loadOne = 1'b1;
            end
         end else if (mStale) begin
            mValid = 1'b0;
            if (redirect) mPc = target;
            if (imem_ack) begin
               mStale = 1'b0;
               mReqA  = mPc;
            end
         end else if (redirect) begin
            mPc    = target;
            mValid = 1'b0;
            if (imem_ack) mReqA = target;
            else mStale = 1'b1;
         end else if (imem_ack) begin
            if (stall) begin
               mHoldQ.push_back(imem_rdata);
            end else begin
               mValid  = 1'b1;
               mInstr  = imem_rdata;
               mIfPc   = mReqA;
               mReqA   = mReqA + 64'd4;
               mPc     = mReqA;
               loadOne = 1'b1;
            end
         end else if (!stall) begin
            mValid = 1'b0;
         end
         if (loadOne) mFetched = mFetched + 32'd1;
         if (!stall && !mValid) mBubbles = mBubbles + 32'd1;
      end
      mRst = rst;
   endtask

   // One comparison: counts it, and reports and counts it if it fails.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Compares every DUT output against the reference model.
   task automatic checkAll();
      checkOutput("imem_req", 64'(imem_req), 64'(modelReq()));
      checkOutput("imem_addr", imem_addr, mReqA);
      checkOutput("ifid_valid", 64'(ifid_valid), 64'(mValid));
      checkOutput("ifid_instr", 64'(ifid_instr), 64'(mInstr));
      checkOutput("ifid_pc", ifid_pc, mIfPc);
      checkOutput("ifid_opcode", 64'(ifid_opcode), 64'(mInstr[31:21]));
`ifdef IF_PERF_EN
      checkOutput("perf_fetched", 64'(perf_fetched), 64'(mFetched));
      checkOutput("perf_bubbles", 64'(perf_bubbles), 64'(mBubbles));
`else
      checkOutput("perf_fetched", 64'(perf_fetched), 64'd0);
      checkOutput("perf_bubbles", 64'(perf_bubbles), 64'd0);
`endif
   endtask

   // Drives one cycle of inputs, steps the model, waits for the edge,
   // and then checks all outputs away from the edge.
   task automatic applyStimulus(input logic r, input logic a, input logic [31:0] d,
                                input logic s, input logic rd,
                                input logic [PC_W-1:0] rp);
      rst         = r;
      imem_ack    = a;
      imem_rdata  = d;
      stall       = s;
      redirect    = rd;
      redirect_pc = rp;
      modelStep();
      @(posedge clk);
      #1;
      checkAll();
   endtask

   initial begin
      logic r;
      logic s;
      logic rd;
      logic a;
      rst         = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      mRst        = 1'b0;

      // Reset
      applyStimulus(0, 0, 32'h0, 0, 0, 64'h0);
      applyStimulus(0, 0, 32'h0, 0, 0, 64'h0);
      checkOutput("reset valid", 64'(ifid_valid), 64'd0);
      checkOutput("reset addr", imem_addr, 64'h0);
      checkOutput("reset req", 64'(imem_req), 64'd0);

      // Zero-wait fetches of ADDI
      applyStimulus(1, 1, 32'h91000421, 0, 0, 64'h0);
      checkOutput("zw pc0", ifid_pc, 64'h0);
      checkOutput("zw addr4", imem_addr, 64'h4);
      applyStimulus(1, 1, 32'h91000421, 0, 0, 64'h0);
      checkOutput("zw pc4", ifid_pc, 64'h4);
      checkOutput("zw opcode", 64'(ifid_opcode), 64'h488);

      // Stall during the ack for address 8
      applyStimulus(1, 1, 32'h91000421, 1, 0, 64'h0);
      checkOutput("hold pc", ifid_pc, 64'h4);
      checkOutput("hold req", 64'(imem_req), 64'd0);
      applyStimulus(1, 0, 32'h0, 1, 0, 64'h0);
      checkOutput("hold pc2", ifid_pc, 64'h4);
      applyStimulus(1, 0, 32'h0, 0, 0, 64'h0);
      checkOutput("release pc", ifid_pc, 64'h8);
      checkOutput("release addr", imem_addr, 64'hC);
      checkOutput("release valid", 64'(ifid_valid), 64'd1);
`ifdef IF_PERF_EN
      checkOutput("fetched3", 64'(perf_fetched), 64'd3);
`endif

      // Redirect with an ack in the same cycle
      applyStimulus(1, 1, 32'h12345678, 0, 1, 64'h40);
      checkOutput("redir valid", 64'(ifid_valid), 64'd0);
      checkOutput("redir addr", imem_addr, 64'h40);
      applyStimulus(1, 1, 32'h8B020020, 0, 0, 64'h0);
      checkOutput("redir pc", ifid_pc, 64'h40);

      // Slow memory with a redirect while a request is waiting
      applyStimulus(1, 0, 32'h0, 0, 0, 64'h0);
      applyStimulus(1, 0, 32'h0, 0, 1, 64'h100);
      checkOutput("drain addr", imem_addr, 64'h44);
      applyStimulus(1, 0, 32'h0, 0, 0, 64'h0);
      checkOutput("drain req", 64'(imem_req), 64'd1);
      applyStimulus(1, 1, 32'hDEADBEEF, 0, 0, 64'h0);
      checkOutput("drain done addr", imem_addr, 64'h100);
      checkOutput("drain valid", 64'(ifid_valid), 64'd0);
      applyStimulus(1, 1, 32'hAA000000, 0, 0, 64'h0);
      checkOutput("drain pc", ifid_pc, 64'h100);
      checkOutput("drain instr", 64'(ifid_instr), 64'hAA000000);

      // Redirect together with stall, while in HOLD
      applyStimulus(1, 1, 32'h11111111, 1, 0, 64'h0);
      applyStimulus(1, 0, 32'h0, 1, 1, 64'h300);
      checkOutput("flush valid", 64'(ifid_valid), 64'd0);
      checkOutput("flush addr", imem_addr, 64'h300);
      applyStimulus(1, 1, 32'h22222222, 0, 0, 64'h0);
      checkOutput("flush instr", 64'(ifid_instr), 64'h22222222);

      // Redirect together with stall while a word is being acked
      applyStimulus(1, 1, 32'h55555555, 1, 1, 64'h80);
      checkOutput("flush2 valid", 64'(ifid_valid), 64'd0);

      // Reset during HOLD
      applyStimulus(1, 1, 32'h0, 0, 1, 64'h200);
      applyStimulus(1, 1, 32'h33333333, 1, 0, 64'h0);
      applyStimulus(0, 0, 32'h0, 1, 0, 64'h0);
      checkOutput("midrst pc", ifid_pc, 64'h0);
      checkOutput("midrst instr", 64'(ifid_instr), 64'h0);
      checkOutput("midrst addr", imem_addr, 64'h0);
      applyStimulus(1, 0, 32'h0, 0, 0, 64'h0);
      checkOutput("post rst req", 64'(imem_req), 64'd1);

      // Wrap of the top address; the low bits of redirect_pc are ignored
      applyStimulus(1, 1, 32'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("wrap top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      applyStimulus(1, 1, 32'h44444444, 0, 0, 64'h0);
      checkOutput("wrap zero", imem_addr, 64'h0);

      // Randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(63) != 0);
         s  = ($urandom_range(3) == 0);
         rd = ($urandom_range(7) == 0);
         a  = r && (mHoldQ.size() == 0) && ($urandom_range(1) == 0);
         applyStimulus(r, a, $urandom(), s, rd, {$urandom(), $urandom()});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipelined ARM CPU. It owns the program counter, issues requests to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register that feeds the decode stage and the CPU control unit. The hazard unit stalls it, and branches resolved downstream redirect and flush it.

## Interface
- PC_W, 64, program-counter and address width
- RESET_PC, 0, PC value loaded by reset
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset rst, synchronous, active-low
- imem_req  output  1  fetch request; address held stable while high until ack
- imem_addr  output  PC_W  fetch address (registered req_addr)
- imem_ack  input  1  imem_rdata valid this cycle; may rise in same cycle as req
- imem_rdata  input  32  fetched instruction word
- stall  input  1  hold IF/ID contents (load-use hazard)
- redirect  input  1  taken branch / BR: flush and refetch
- redirect_pc  input  PC_W  new PC when redirect high
- ifid_valid  output  1  IF/ID holds a real instruction
- ifid_instr  output  32  IF/ID instruction
- ifid_pc  output  PC_W  PC of ifid_instr (for branch target / BL link)
- ifid_opcode  output  11  ifid_instr[31:21], drives control-unit opcode input
- perf_fetched  output  32  accepted-instruction count (see Configuration)
- perf_bubbles  output  32  bubble-cycle count (see Configuration)

## Operation
- Registers: pc, req_addr, hold_buf (32b), state, IF/ID (valid, instr, pc).
- States: FETCH, HOLD, DRAIN.
- FETCH: imem_req=1, imem_addr=req_addr.
  - ack & !redirect & !stall: IF/ID <= {1, rdata, req_addr}; pc, req_addr <= req_addr+4.
  - ack & !redirect & stall: hold_buf <= rdata; -> HOLD; IF/ID unchanged.
  - ack & redirect: data dropped; pc, req_addr <= redirect_pc; IF/ID valid <= 0.
  - !ack & redirect: pc <= redirect_pc; req_addr unchanged; -> DRAIN; IF/ID valid <= 0.
  - !ack & !redirect: IF/ID valid <= 0 if !stall, else unchanged.
- HOLD: imem_req=0. !stall & !redirect: IF/ID <= {1, hold_buf, req_addr}; req_addr, pc <= req_addr+4; -> FETCH. redirect: buffer dropped, req_addr, pc <= redirect_pc, IF/ID valid <= 0, -> FETCH.
- DRAIN: imem_req=1 at old req_addr; on ack data dropped, req_addr <= pc, -> FETCH. A further redirect in DRAIN overwrites pc only. IF/ID valid <= 0 each DRAIN cycle.
- Priority: rst > redirect > stall. Redirect flushes IF/ID even when stall is high.
- PC arithmetic modulo 2^PC_W; +4 wraps silently. redirect_pc[1:0] is forced to 0.
- ifid_opcode is a pure slice of ifid_instr.

## Timing
- Reset (rst=0 at edge): pc=req_addr=RESET_PC, state=FETCH, ifid_valid=0, ifid_instr=0, ifid_pc=0, hold_buf=0, counters 0. imem_req=1 in the first cycle after rst returns high. imem_req=0 while rst=0.
- Reset mid-request discards the outstanding request. The memory shares rst.
- Zero-wait memory (ack in req cycle): 1 instruction/cycle. Ack in cycle n -> ifid_valid=1 in cycle n+1.
- Redirect in cycle n with no outstanding request: imem_addr=redirect_pc in n+1, and the first redirected instruction appears in IF/ID at n+2 at the earliest.
- Stall is sampled each edge. IF/ID is frozen for exactly the cycles stall=1, and at most one fetched word is buffered.

## Configuration
- IF_PERF_EN defined: perf_fetched increments on each IF/ID load with valid=1. perf_bubbles increments on each edge where stall=0 and IF/ID loads valid=0. Both wrap modulo 2^32 and are cleared by rst.
- IF_PERF_EN undefined: no counter registers; perf_fetched and perf_bubbles tied to 0.

## Test plan
- Reset, RESET_PC=0, zero-wait memory, rdata=0x91000421 -> imem_addr 0,4,8,... per cycle; ifid_pc 0,4,8; ifid_opcode=0x488 (ADDI); perf_fetched=3 after 3 fetches.
- stall high 2 cycles during ack at addr 8 -> IF/ID holds addr 4 for 2 cycles, imem_req=0 in HOLD, then ifid_pc=8 and next imem_addr=0xC.
- redirect=1, redirect_pc=0x40, with ack in the same cycle -> ifid_valid=0 next cycle, imem_addr=0x40 next cycle, ifid_pc=0x40 one cycle later.
- 3-cycle memory latency with redirect to 0x100 in wait cycle 1 -> DRAIN keeps imem_addr at the old address until ack, that word is never in IF/ID, then imem_addr=0x100.
- redirect and stall both high -> ifid_valid=0 next cycle (flush wins); HOLD buffer discarded.
- rst=0 mid-HOLD with pc=0x200 -> all outputs reach reset values at next edge; first request after release at RESET_PC; pc=0xFFFF_FFFF_FFFF_FFFC advances to 0.
